// File: rtl/lp_riscv_top.sv
`default_nettype none
// ============================================================================
// Module : lp_riscv_top
// Brief  : In-place unsigned bubble sort of a RAM-resident vector, followed by
//          a search for the original first element; IRAM programming port and
//          per-input event counters.
// Rev    : 1.0
// ============================================================================

module lp_sp_ram #(
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    // No reset and no initialisation so contents can be preloaded externally.
    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end
endmodule

module lp_dccm_bank (
    input  logic        clk,
    input  logic        en,
    input  logic        we,
    input  logic [13:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    lp_sp_ram #(.DEPTH(16384), .AW(14)) ram (
        .clk(clk), .en(en), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
    );
endmodule

module lp_dccm_wrapper (
    input  logic        clk,
    input  logic        en,
    input  logic        we,
    input  logic [13:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    lp_dccm_bank dccm_ram_0 (
        .clk(clk), .en(en), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
    );
endmodule

module lp_riscv_core #(
    parameter int          N_ELEM    = 24,
    parameter logic [31:0] SORT_BASE = 32'h2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clock_en,
    input  logic        test_en,
    input  logic        fetch_en,
    input  logic [15:0] ext_perf,
    input  logic [7:0]  prog_byte,
    input  logic [1:0]  prog_idx,
    input  logic        prog_data_byte,
    input  logic        prog_addr_byte,
    input  logic        prog_wr,
    output logic        done_flag
);
    localparam int          IW        = $clog2(N_ELEM) + 1;
    localparam logic [13:0] BASE_W    = SORT_BASE[15:2];
    localparam logic [IW-1:0] LAST    = IW'(N_ELEM - 2);
    localparam logic [IW-1:0] FINAL_IX = IW'(N_ELEM - 1);

    typedef enum logic [3:0] {
        IDLE, KEY_RD, KEY_CAP, RD_A, RD_B, CMP, WR_A, WR_B, NEXT,
        FIND_RD, FIND_CMP, WR_IDX, DONE
    } state_t;

    logic [1:0]    rst_sync;
    logic          rst_n_int;
    state_t        state, state_nxt;
    logic [31:0]   key, a_q, b_q;
    logic [IW-1:0] j, pass, idx;
    logic          last_j, last_pass;
    logic [13:0]   ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata, ram_rdata;

    // Assert asynchronously, release two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    // Pass p compares pairs j = 0 .. N_ELEM-2-p; the tail is already final.
    assign last_j    = (j == (LAST - pass));
    assign last_pass = (pass == LAST);

    always_comb begin
        state_nxt = state;
        ram_addr  = BASE_W + 14'(j);
        ram_we    = 1'b0;
        ram_wdata = a_q;
        case (state)
            IDLE:     if (fetch_en) state_nxt = KEY_RD;
            KEY_RD: begin
                ram_addr  = BASE_W;
                state_nxt = KEY_CAP;
            end
            KEY_CAP:  state_nxt = RD_A;
            RD_A:     state_nxt = RD_B;
            RD_B: begin
                ram_addr  = BASE_W + 14'(j) + 14'd1;
                state_nxt = CMP;
            end
            CMP:      state_nxt = (a_q > ram_rdata) ? WR_A : NEXT;
            WR_A: begin
                ram_we    = 1'b1;
                ram_wdata = b_q;
                state_nxt = WR_B;
            end
            WR_B: begin
                ram_addr  = BASE_W + 14'(j) + 14'd1;
                ram_we    = 1'b1;
                ram_wdata = a_q;
                state_nxt = NEXT;
            end
            NEXT:     state_nxt = (last_j && last_pass) ? FIND_RD : RD_A;
            FIND_RD: begin
                ram_addr  = BASE_W + 14'(idx);
                state_nxt = FIND_CMP;
            end
            FIND_CMP: state_nxt = ((ram_rdata == key) || (idx == FINAL_IX)) ? WR_IDX : FIND_RD;
            WR_IDX: begin
                ram_addr  = BASE_W - 14'd1;
                ram_we    = 1'b1;
                ram_wdata = 32'(idx);
                state_nxt = DONE;
            end
            DONE:     state_nxt = DONE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state     <= IDLE;
            key       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            j         <= '0;
            pass      <= '0;
            idx       <= '0;
            done_flag <= 1'b0;
        end else if (clock_en) begin
            state <= state_nxt;
            case (state)
                KEY_CAP: begin
                    key  <= ram_rdata;
                    j    <= '0;
                    pass <= '0;
                end
                RD_B: a_q <= ram_rdata;
                CMP:  b_q <= ram_rdata;
                NEXT: begin
                    if (!last_j) begin
                        j <= j + 1'b1;
                    end else begin
                        j    <= '0;
                        pass <= pass + 1'b1;
                    end
                end
                FIND_CMP: if (state_nxt == FIND_RD) idx <= idx + 1'b1;
                default: ;
            endcase
            if (state_nxt == DONE) done_flag <= 1'b1;
        end
    end

    lp_dccm_wrapper dccm_ram_wrapper (
        .clk(clk), .en(clock_en), .we(ram_we), .addr(ram_addr),
        .wdata(ram_wdata), .rdata(ram_rdata)
    );

    (* keep *) logic              test_mode;
    (* keep *) logic [31:0]       addr_stage;
    (* keep *) logic [31:0]       data_stage;
    (* keep *) logic [15:0][31:0] iram;
    (* keep *) logic [15:0][31:0] perf_cnt;
    logic [31:0] data_next;

    always_comb begin
        data_next = data_stage;
        data_next[{prog_idx, 3'b000} +: 8] = prog_byte;
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            test_mode  <= 1'b0;
            addr_stage <= '0;
            data_stage <= '0;
            iram       <= '0;
            perf_cnt   <= '0;
        end else if (clock_en) begin
            test_mode <= test_en;
            if (prog_wr) begin
                if (prog_addr_byte) addr_stage[{prog_idx, 3'b000} +: 8] <= prog_byte;
                if (prog_data_byte) begin
                    data_stage <= data_next;
                    // Lane 3 completes the word, including the byte arriving now.
                    if (prog_idx == 2'd3) iram[addr_stage[3:0]] <= data_next;
                end
            end
            for (int k = 0; k < 16; k++) begin
                if (ext_perf[k]) perf_cnt[k] <= perf_cnt[k] + 32'd1;
            end
        end
    end

    // Observation-only state: folded into a sink so it is retained but never read.
    logic unused_sink;
    assign unused_sink = ^{test_mode, addr_stage[31:4], iram, perf_cnt};
endmodule

module lp_riscv_top #(
    parameter int          N_ELEM    = 24,
    parameter logic [31:0] SORT_BASE = 32'h2000
) (
    input  logic PAD_CLK,
    input  logic PAD_RST_N,
    input  logic PAD_CLOCK_EN,
    input  logic PAD_TEST_EN,
    input  logic PAD_FETCH_EN,
    input  logic PAD_EXT_PERF_COUNTERS_0,
    input  logic PAD_EXT_PERF_COUNTERS_1,
    input  logic PAD_EXT_PERF_COUNTERS_2,
    input  logic PAD_EXT_PERF_COUNTERS_3,
    input  logic PAD_EXT_PERF_COUNTERS_4,
    input  logic PAD_EXT_PERF_COUNTERS_5,
    input  logic PAD_EXT_PERF_COUNTERS_6,
    input  logic PAD_EXT_PERF_COUNTERS_7,
    input  logic PAD_EXT_PERF_COUNTERS_8,
    input  logic PAD_EXT_PERF_COUNTERS_9,
    input  logic PAD_EXT_PERF_COUNTERS_10,
    input  logic PAD_EXT_PERF_COUNTERS_11,
    input  logic PAD_EXT_PERF_COUNTERS_12,
    input  logic PAD_EXT_PERF_COUNTERS_13,
    input  logic PAD_EXT_PERF_COUNTERS_14,
    input  logic PAD_EXT_PERF_COUNTERS_15,
    input  logic PAD_IRAM_PROG_BYTE_0,
    input  logic PAD_IRAM_PROG_BYTE_1,
    input  logic PAD_IRAM_PROG_BYTE_2,
    input  logic PAD_IRAM_PROG_BYTE_3,
    input  logic PAD_IRAM_PROG_BYTE_4,
    input  logic PAD_IRAM_PROG_BYTE_5,
    input  logic PAD_IRAM_PROG_BYTE_6,
    input  logic PAD_IRAM_PROG_BYTE_7,
    input  logic PAD_IRAM_PROG_BYTE_IDX_0,
    input  logic PAD_IRAM_PROG_BYTE_IDX_1,
    input  logic PAD_IRAM_PROG_DATA_BYTE,
    input  logic PAD_IRAM_PROG_ADDR_BYTE,
    input  logic PAD_IRAM_PROG_WR,
    output logic PAD_DONE_FLAG
);
    lp_riscv_core #(.N_ELEM(N_ELEM), .SORT_BASE(SORT_BASE)) lp_riscv (
        .clk            (PAD_CLK),
        .rst_n          (PAD_RST_N),
        .clock_en       (PAD_CLOCK_EN),
        .test_en        (PAD_TEST_EN),
        .fetch_en       (PAD_FETCH_EN),
        .ext_perf       ({PAD_EXT_PERF_COUNTERS_15, PAD_EXT_PERF_COUNTERS_14,
                          PAD_EXT_PERF_COUNTERS_13, PAD_EXT_PERF_COUNTERS_12,
                          PAD_EXT_PERF_COUNTERS_11, PAD_EXT_PERF_COUNTERS_10,
                          PAD_EXT_PERF_COUNTERS_9,  PAD_EXT_PERF_COUNTERS_8,
                          PAD_EXT_PERF_COUNTERS_7,  PAD_EXT_PERF_COUNTERS_6,
                          PAD_EXT_PERF_COUNTERS_5,  PAD_EXT_PERF_COUNTERS_4,
                          PAD_EXT_PERF_COUNTERS_3,  PAD_EXT_PERF_COUNTERS_2,
                          PAD_EXT_PERF_COUNTERS_1,  PAD_EXT_PERF_COUNTERS_0}),
        .prog_byte      ({PAD_IRAM_PROG_BYTE_7, PAD_IRAM_PROG_BYTE_6,
                          PAD_IRAM_PROG_BYTE_5, PAD_IRAM_PROG_BYTE_4,
                          PAD_IRAM_PROG_BYTE_3, PAD_IRAM_PROG_BYTE_2,
                          PAD_IRAM_PROG_BYTE_1, PAD_IRAM_PROG_BYTE_0}),
        .prog_idx       ({PAD_IRAM_PROG_BYTE_IDX_1, PAD_IRAM_PROG_BYTE_IDX_0}),
        .prog_data_byte (PAD_IRAM_PROG_DATA_BYTE),
        .prog_addr_byte (PAD_IRAM_PROG_ADDR_BYTE),
        .prog_wr        (PAD_IRAM_PROG_WR),
        .done_flag      (PAD_DONE_FLAG)
    );
endmodule

`default_nettype wire

// File: tb/tb_lp_riscv_top.sv
`default_nettype none
// ============================================================================
// Module : tb_lp_riscv_top
// Brief  : Scoreboard bench for lp_riscv_top; expected vectors come from a
//          queue-sort reference model.
// Rev    : 1.0
// ============================================================================
module tb_lp_riscv_top;
    localparam int          N        = 24;
    localparam int          BASE     = 'h800;
    localparam logic [31:0] SENT_LO  = 32'hA5A5_0001;
    localparam logic [31:0] SENT_HI  = 32'h5A5A_0002;
    localparam logic [31:0] IDX_INIT = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [N-1:0][31:0] vec;
        logic [31:0]        idx;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, clock_en = 1'b1, test_en = 1'b0, fetch_en = 1'b1;
    logic [15:0] perf_in = '0;
    logic [7:0]  pbyte = '0;
    logic [1:0]  pidx = '0;
    logic        pdata = 1'b0, paddr = 1'b0, pwr = 1'b0;
    logic        done;

    exp_t        sb_q[$];
    logic [31:0] stim [N];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    lp_riscv_top dut (
        .PAD_CLK(clk), .PAD_RST_N(rst_n), .PAD_CLOCK_EN(clock_en),
        .PAD_TEST_EN(test_en), .PAD_FETCH_EN(fetch_en),
        .PAD_EXT_PERF_COUNTERS_0(perf_in[0]),   .PAD_EXT_PERF_COUNTERS_1(perf_in[1]),
        .PAD_EXT_PERF_COUNTERS_2(perf_in[2]),   .PAD_EXT_PERF_COUNTERS_3(perf_in[3]),
        .PAD_EXT_PERF_COUNTERS_4(perf_in[4]),   .PAD_EXT_PERF_COUNTERS_5(perf_in[5]),
        .PAD_EXT_PERF_COUNTERS_6(perf_in[6]),   .PAD_EXT_PERF_COUNTERS_7(perf_in[7]),
        .PAD_EXT_PERF_COUNTERS_8(perf_in[8]),   .PAD_EXT_PERF_COUNTERS_9(perf_in[9]),
        .PAD_EXT_PERF_COUNTERS_10(perf_in[10]), .PAD_EXT_PERF_COUNTERS_11(perf_in[11]),
        .PAD_EXT_PERF_COUNTERS_12(perf_in[12]), .PAD_EXT_PERF_COUNTERS_13(perf_in[13]),
        .PAD_EXT_PERF_COUNTERS_14(perf_in[14]), .PAD_EXT_PERF_COUNTERS_15(perf_in[15]),
        .PAD_IRAM_PROG_BYTE_0(pbyte[0]), .PAD_IRAM_PROG_BYTE_1(pbyte[1]),
        .PAD_IRAM_PROG_BYTE_2(pbyte[2]), .PAD_IRAM_PROG_BYTE_3(pbyte[3]),
        .PAD_IRAM_PROG_BYTE_4(pbyte[4]), .PAD_IRAM_PROG_BYTE_5(pbyte[5]),
        .PAD_IRAM_PROG_BYTE_6(pbyte[6]), .PAD_IRAM_PROG_BYTE_7(pbyte[7]),
        .PAD_IRAM_PROG_BYTE_IDX_0(pidx[0]), .PAD_IRAM_PROG_BYTE_IDX_1(pidx[1]),
        .PAD_IRAM_PROG_DATA_BYTE(pdata), .PAD_IRAM_PROG_ADDR_BYTE(paddr),
        .PAD_IRAM_PROG_WR(pwr),
        .PAD_DONE_FLAG(done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rd(input int a);
        return dut.lp_riscv.dccm_ram_wrapper.dccm_ram_0.ram.mem[14'(a)];
    endfunction

    task automatic wr(input int a, input logic [31:0] v);
        dut.lp_riscv.dccm_ram_wrapper.dccm_ram_0.ram.mem[14'(a)] = v;
    endtask

    // Reference: ascending unsigned sort; IDX = first sorted position of the original word 0.
    function automatic exp_t model();
        logic [31:0] q[$];
        exp_t        e;
        for (int i = 0; i < N; i++) q.push_back(stim[i]);
        q.sort();
        e.idx = 32'd0;
        for (int i = N - 1; i >= 0; i--) begin
            e.vec[i] = q[i];
            if (q[i] == stim[0]) e.idx = 32'(i);
        end
        return e;
    endfunction

    task automatic start_run();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) wr(BASE + i, stim[i]);
        wr(BASE - 1, IDX_INIT);
        wr(BASE - 2, SENT_LO);
        wr(BASE + N, SENT_HI);
        sb_q.push_back(model());
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (!done && n < limit + 200) begin
            @(negedge clk);
            if (clock_en) n++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_latency_ok"}, 32'(n <= limit), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: on each rising DONE, pop the oldest expectation and compare RAM.
    initial begin : monitor
        logic seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !seen) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    check("done_without_expectation", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    for (int i = 0; i < N; i++)
                        check($sformatf("word%0d", i), rd(BASE + i), e.vec[i]);
                    check("idx_word", rd(BASE - 1), e.idx);
                    check("sentinel_lo", rd(BASE - 2), SENT_LO);
                    check("sentinel_hi", rd(BASE + N), SENT_HI);
                end
            end else if (!done) begin
                seen = 1'b0;
            end
        end
    end

    // Background activity on the side ports.
    initial begin : side_ports
        forever begin
            @(negedge clk);
            perf_in = 16'($urandom());
            pbyte   = 8'($urandom());
            pidx    = 2'($urandom());
            pdata   = 1'($urandom());
            paddr   = 1'($urandom());
            pwr     = 1'($urandom());
            test_en = 1'($urandom());
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] q[$];
        logic [31:0] t;
        repeat (3) @(negedge clk);
        check("reset_done_low", 32'(done), 32'd0);

        // Key 2083895770 followed by random words.
        stim[0] = 32'd2083895770;
        for (int i = 1; i < N; i++) stim[i] = $urandom();
        start_run();
        wait_done("random_key", 4000);
        #2 rst_n = 1'b0;
        #1 check("done_async_clear", 32'(done), 32'd0);

        // Worst case: strictly descending.
        for (int i = 0; i < N; i++) stim[i] = 32'(N - i);
        start_run();
        wait_done("descending", 4000);

        // All equal.
        for (int i = 0; i < N; i++) stim[i] = 32'd5;
        start_run();
        wait_done("all_equal", 4000);

        // Unsigned extremes with a top-bit-set key.
        for (int i = 0; i < N; i++) stim[i] = $urandom();
        stim[0]  = 32'h8000_0000;
        stim[5]  = 32'hFFFF_FFFF;
        stim[11] = 32'h0000_0001;
        start_run();
        wait_done("unsigned_extremes", 4000);

        // Clock enable held low for 50 cycles mid-sort.
        for (int i = 0; i < N; i++) stim[i] = $urandom();
        start_run();
        repeat (300) @(negedge clk);
        clock_en = 1'b0;
        repeat (50) @(negedge clk);
        check("pause_no_done", 32'(done), 32'd0);
        clock_en = 1'b1;
        wait_done("pause", 4000);

        // Reset mid-sort. Only disjoint adjacent pairs are out of order, so every swap
        // lands in the first pass and the vector is stable when reset hits.
        q.delete();
        for (int i = 0; i < N; i++) q.push_back($urandom() | 32'd1);
        q.sort();
        for (int i = 0; i < N; i++) stim[i] = q[i];
        stim[0] = 32'd0;
        t = stim[1];  stim[1]  = stim[2];  stim[2]  = t;
        t = stim[3];  stim[3]  = stim[4];  stim[4]  = t;
        t = stim[10]; stim[10] = stim[11]; stim[11] = t;
        start_run();
        repeat (500) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check("midsort_reset_done_low", 32'(done), 32'd0);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        wait_done("after_midsort_reset", 4000);

        // Fetch enable low: nothing may move.
        fetch_en = 1'b0;
        for (int i = 0; i < N; i++) stim[i] = $urandom();
        start_run();
        repeat (200) @(negedge clk);
        check("fetch_off_done_low", 32'(done), 32'd0);
        for (int i = 0; i < N; i++)
            check($sformatf("fetch_off_word%0d", i), rd(BASE + i), stim[i]);
        check("fetch_off_idx_word", rd(BASE - 1), IDX_INIT);
        fetch_en = 1'b1;
        wait_done("fetch_on", 4000);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lp_riscv_top.md
LP_RISCV_TOP -- requirements
Module: lp_riscv_top

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports PAD_CLK and PAD_RST_N.
REQ-002 Parameter N_ELEM, default 24: number of 32-bit words sorted.
REQ-003 Parameter SORT_BASE, default 32'h2000: byte address of the vector, word index 0x800.
REQ-004 PAD_CLK  in  1  system clock; all state updates on its rising edge.
REQ-005 PAD_RST_N  in  1  asynchronous active-low reset.
REQ-006 PAD_CLOCK_EN  in  1  global enable; low freezes all state, memory writes included.
REQ-007 PAD_TEST_EN  in  1  test mode; registered into a status flop only, no functional effect.
REQ-008 PAD_FETCH_EN  in  1  start permission; the sequencer leaves IDLE only while high.
REQ-009 PAD_EXT_PERF_COUNTERS_0..15  in  1 each  external event inputs, one port per bit.
REQ-010 PAD_IRAM_PROG_BYTE_0..7  in  1 each  programming byte, bit 0 is LSB.
REQ-011 PAD_IRAM_PROG_BYTE_IDX_0..1  in  1 each  byte lane 0..3 within a 32-bit word.
REQ-012 PAD_IRAM_PROG_DATA_BYTE  in  1  qualifies the byte as a data byte.
REQ-013 PAD_IRAM_PROG_ADDR_BYTE  in  1  qualifies the byte as an address byte.
REQ-014 PAD_IRAM_PROG_WR  in  1  programming write strobe, one write per cycle.
REQ-015 PAD_DONE_FLAG  out  1  goes high when the sort and index write have completed.

Function
REQ-016 SHALL contain a 16384x32 single-port, synchronous-read, word-addressed data RAM at hierarchy lp_riscv.dccm_ram_wrapper.dccm_ram_0.ram, array named mem, with no reset and no initialisation, so a bench can backdoor-load it.
REQ-017 Sequencer states: IDLE, KEY_RD, KEY_CAP, RD_A, RD_B, CMP, WR_A, WR_B, NEXT, FIND_RD, FIND_CMP, WR_IDX, DONE.
REQ-018 IDLE -> KEY_RD when PAD_FETCH_EN=1 and PAD_CLOCK_EN=1.
REQ-019 KEY_RD/KEY_CAP read mem[0x800] and hold it as KEY, the pre-sort first element.
REQ-020 Sort is ascending, 32-bit unsigned compare, in place over mem[0x800..0x800+N_ELEM-1].
REQ-021 Sort algorithm is bubble sort:
- RD_A/RD_B read words j and j+1; CMP compares them.
- WR_A/WR_B swap the two words only if word j > word j+1; equal words are not swapped.
- NEXT advances j, then the pass.
- Exactly N_ELEM-1 passes; an early exit on a pass with no swap is permitted.
REQ-022 FIND_RD/FIND_CMP scan the sorted vector from index 0 upward for the first word equal to KEY; the match index is IDX.
REQ-023 WR_IDX writes IDX, zero-extended to 32 bits, to mem[0x7FF] (byte 0x1FFC).
REQ-024 DONE asserts PAD_DONE_FLAG, registered, and holds it high until reset; there is no restart without reset.
REQ-025 Total latency from reset release to PAD_DONE_FLAG with N_ELEM=24 SHALL be at most 4000 enabled cycles.
REQ-026 While PAD_CLOCK_EN=0, state, counters and RAM are held; the sequence resumes with identical results.
REQ-027 Words outside 0x7FF..0x817 SHALL never be written by the sequencer.
REQ-028 IRAM programming path, on a cycle with PAD_IRAM_PROG_WR=1:
- ADDR_BYTE=1 loads the byte into lane IDX of a 32-bit address staging register.
- DATA_BYTE=1 loads the byte into lane IDX of a 32-bit data staging register.
- Both high: both registers load.
- A write with IDX=3 and DATA_BYTE=1 commits the data staging register to a 16x32 IRAM at address staging[3:0].
- IRAM is marked keep and is never read by the sequencer.
REQ-029 Perf counters: a 32-bit counter per input bit, incremented each enabled cycle the bit is high, wrapping at 2^32; marked keep, with no output.

Reset
REQ-030 PAD_RST_N low, at any time and asynchronously: state=IDLE, PAD_DONE_FLAG=0, KEY, IDX, loop indices, staging registers, IRAM and perf counters cleared; RAM contents untouched.
REQ-031 Reset mid-sort aborts the sort; after release, sorting restarts on the RAM contents as left, partially swapped.
REQ-032 Reset release is synchronised internally with a two-flop synchroniser; the sequencer acts no earlier than the 2nd rising edge after release.

Verification
REQ-033 Preload words 0x800..0x817 = {2083895770, 23 pseudo-random values}, pulse reset 100 ns -> DONE rises; words 0x800..0x817 ascending unsigned; mem[0x7FF] = final position of 2083895770.
REQ-034 Preload 24 descending values 24..1 -> sorted 1..24; mem[0x7FF]=23; DONE within 4000 cycles.
REQ-035 Preload all words equal 5 -> vector unchanged; mem[0x7FF]=0.
REQ-036 Preload including 0xFFFFFFFF and 0x00000001, with word 0x800=0x80000000 -> 0xFFFFFFFF sorted last (unsigned); mem[0x7FF] = position of 0x80000000.
REQ-037 Hold PAD_CLOCK_EN=0 for 50 cycles mid-sort -> same final result as the uninterrupted run; assert reset mid-sort -> DONE=0 at once, and a correct sort completes after release.
REQ-038 PAD_FETCH_EN=0 after reset -> no RAM writes and DONE stays 0; raise it -> normal completion.
